prog_mem_loader: RTL and testbench

PROG_MEM_LOADER -- requirements
Module: prog_mem_loader

---
 rtl/prog_mem_loader.sv | 207 ++++++++++++++++++++
 tb/tb_prog_mem_loader.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_mem_loader.sv
// -----------------------------------------------------------------------------
// prog_mem_loader
//
// Purpose:
//   Receives a program image as a serial byte stream and writes it into the
//   CPU program memory. Once the image is loaded, it releases the CPU from
//   reset and lets it run. When the CPU halts, a new image can be loaded.
//
//   Stream format:
//     - word count N, two bytes, MSB first
//     - N words, each sent as high byte then low byte
//     - with LOADER_CHECKSUM_EN only: one trailing byte equal to the XOR of
//       all data bytes
//
//   Words are written starting at address 0. Any word that would fall beyond
//   the last memory address is dropped and load_err is set; its bytes are
//   still consumed from the stream.
//
// Handshake:
//   rx_valid is a one-cycle strobe with no back-pressure: rx_data is taken in
//   any cycle where rx_valid=1 and the FSM is in a byte-accepting state
//   (HDR_HI, HDR_LO, DAT_HI, DAT_LO, HALTED, and FINISH in checksum builds).
//   In other states the strobe is dropped. mem_wr is a one-cycle write pulse
//   with no acknowledge.
//
// Configuration:
//   LOADER_CHECKSUM_EN -- when defined, FINISH waits for the checksum byte.
//
// Ports:
//   clk        system clock; all state changes on the rising edge
//   reset      synchronous, active-high
//   rx_data    received serial byte
//   rx_valid   rx_data is valid in this cycle
//   cpu_addr   CPU fetch address; drives mem_addr while in RUN
//   cpu_halt   CPU has executed HALT
//   mem_addr   program memory address
//   mem_wr     program memory write enable (one-cycle pulse)
//   mem_data   program memory write data {hi, lo}
//   cpu_run    CPU enable
//   cpu_reset  CPU reset; high in every state except RUN
//   load_err   sticky error flag (empty image, overflow, bad checksum)
//   dbg_state  current FSM state, for debug and checkers
// -----------------------------------------------------------------------------
module prog_mem_loader #(
  parameter int ADDR_LENGTH = 11,
  parameter int DATA_LENGTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  input  logic [ADDR_LENGTH-1:0] cpu_addr,
  input  logic                   cpu_halt,
  output logic [ADDR_LENGTH-1:0] mem_addr,
  output logic                   mem_wr,
  output logic [DATA_LENGTH-1:0] mem_data,
  output logic                   cpu_run,
  output logic                   cpu_reset,
  output logic                   load_err,
  output logic [2:0]             dbg_state
);

  typedef enum logic [2:0] {
    HDR_HI = 3'd0,
    HDR_LO = 3'd1,
    DAT_HI = 3'd2,
    DAT_LO = 3'd3,
    FINISH = 3'd4,
    RUN    = 3'd5,
    HALTED = 3'd6
  } state_t;

  state_t                 state;
  logic [7:0]             hdr_hi;
  logic [7:0]             dat_hi;
  logic [15:0]            words_left;
  logic [ADDR_LENGTH-1:0] load_addr;
  // Set once the word at the last address has been written; every later
  // word in the same load is dropped.
  logic                   addr_full;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]             csum;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= HDR_HI;
      hdr_hi     <= 8'd0;
      dat_hi     <= 8'd0;
      words_left <= 16'd0;
      load_addr  <= '0;
      addr_full  <= 1'b0;
      mem_wr     <= 1'b0;
      mem_data   <= '0;
      cpu_run    <= 1'b0;
      cpu_reset  <= 1'b1;
      load_err   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum       <= 8'd0;
`endif
    end else begin
      mem_wr <= 1'b0;

      // The load address must stay stable for the whole write pulse, so it
      // advances on the edge that ends the pulse. The next low byte needs a
      // high byte first, so it always sees the updated address.
      if (mem_wr) begin
        if (load_addr == '1) addr_full <= 1'b1;
        load_addr <= load_addr + 1'b1;
      end

      case (state)
        HDR_HI, HALTED: begin
          if (rx_valid) begin
            hdr_hi    <= rx_data;
            load_addr <= '0;
            addr_full <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum      <= 8'd0;
`endif
            // Only a restart after HALTED clears the error; an empty header
            // in HDR_HI leaves it visible.
            if (state == HALTED) load_err <= 1'b0;
            state <= HDR_LO;
          end
        end

        HDR_LO: begin
          if (rx_valid) begin
            if ({hdr_hi, rx_data} == 16'd0) begin
              load_err <= 1'b1;
              state    <= HDR_HI;
            end else begin
              words_left <= {hdr_hi, rx_data};
              state      <= DAT_HI;
            end
          end
        end

        DAT_HI: begin
          if (rx_valid) begin
            dat_hi <= rx_data;
`ifdef LOADER_CHECKSUM_EN
            csum   <= csum ^ rx_data;
`endif
            state  <= DAT_LO;
          end
        end

        DAT_LO: begin
          if (rx_valid) begin
`ifdef LOADER_CHECKSUM_EN
            csum <= csum ^ rx_data;
`endif
            if (addr_full) begin
              load_err <= 1'b1;
            end else begin
              mem_wr   <= 1'b1;
              mem_data <= {dat_hi, rx_data};
            end
            words_left <= words_left - 16'd1;
            state      <= (words_left == 16'd1) ? FINISH : DAT_HI;
          end
        end

        FINISH: begin
`ifdef LOADER_CHECKSUM_EN
          if (rx_valid) begin
            if (rx_data == csum) begin
              cpu_run   <= 1'b1;
              cpu_reset <= 1'b0;
              state     <= RUN;
            end else begin
              load_err <= 1'b1;
              state    <= HALTED;
            end
          end
`else
          cpu_run   <= 1'b1;
          cpu_reset <= 1'b0;
          state     <= RUN;
`endif
        end

        RUN: begin
          if (cpu_halt) begin
            cpu_run   <= 1'b0;
            cpu_reset <= 1'b1;
            state     <= HALTED;
          end
        end

        default: state <= HDR_HI;
      endcase
    end
  end

  // The CPU owns the address bus while running; otherwise it shows the
  // registered load address.
  always_comb begin
    mem_addr = load_addr;
    if (state == RUN) mem_addr = cpu_addr;
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_prog_mem_loader.sv
module tb_prog_mem_loader;

  localparam int AL    = 11;
  localparam int DEPTH = 1 << AL;
  localparam int W     = AL + 16;

  localparam logic [2:0] S_HDR_HI = 3'd0;
  localparam logic [2:0] S_FINISH = 3'd4;
  localparam logic [2:0] S_RUN    = 3'd5;
  localparam logic [2:0] S_HALTED = 3'd6;

  logic          clk;
  logic          reset;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic [AL-1:0] cpu_addr;
  logic          cpu_halt;
  logic [AL-1:0] mem_addr;
  logic          mem_wr;
  logic [15:0]   mem_data;
  logic          cpu_run;
  logic          cpu_reset;
  logic          load_err;
  logic [2:0]    dbg_state;

  int            n_checks;
  int            n_fail;
  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  exp_word;
  logic          prev_wr;

  prog_mem_loader #(.ADDR_LENGTH(AL), .DATA_LENGTH(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .cpu_addr  (cpu_addr),
    .cpu_halt  (cpu_halt),
    .mem_addr  (mem_addr),
    .mem_wr    (mem_wr),
    .mem_data  (mem_data),
    .cpu_run   (cpu_run),
    .cpu_reset (cpu_reset),
    .load_err  (load_err),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  // Every write pulse must match the next expected {addr, data} and last
  // exactly one cycle.
  initial prev_wr = 1'b0;
  always @(negedge clk) begin
    if (mem_wr === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got addr=%h data=%h, required no write", mem_addr, mem_data);
      end else begin
        exp_word = exp_q.pop_front();
        if ({mem_addr, mem_data} !== exp_word) begin
          n_fail++;
          $display("FAIL write_data: got addr=%h data=%h, required addr=%h data=%h",
                   mem_addr, mem_data, exp_word[W-1:16], exp_word[15:0]);
        end
      end
      n_checks++;
      if (prev_wr === 1'b1) begin
        n_fail++;
        $display("FAIL wr_pulse_width: mem_wr high 2 cycles, required 1");
      end
    end
    prev_wr = mem_wr;
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic halt_cpu();
    cpu_halt = 1'b1;
    @(posedge clk);
    #1;
    cpu_halt = 1'b0;
  endtask

  // Sends a full image of n random words with random gaps up to maxgap,
  // pushing the expected writes as it goes.
  task automatic load_stream(input int n, input int maxgap);
    logic [7:0]  cs;
    logic [15:0] w;
    cs = 8'd0;
    send_byte(n[15:8]);
    idle($urandom_range(maxgap, 0));
    send_byte(n[7:0]);
    for (int i = 0; i < n; i++) begin
      w = 16'($urandom);
      idle($urandom_range(maxgap, 0));
      send_byte(w[15:8]);
      idle($urandom_range(maxgap, 0));
      if (i < DEPTH) exp_q.push_back({AL'(i), w});
      send_byte(w[7:0]);
      cs = cs ^ w[15:8] ^ w[7:0];
    end
`ifdef LOADER_CHECKSUM_EN
    idle($urandom_range(maxgap, 0));
    send_byte(cs);
`endif
  endtask

  // Bounded wait for cpu_run, then confirm every expected write appeared.
  task automatic wait_run(input string name);
    int k;
    k = 0;
    while (cpu_run !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (cpu_run !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_run: cpu_run=%b, required 1 within 20 cycles", name, cpu_run);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d writes outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_checks++; if (mem_wr !== 1'b0)     begin n_fail++; $display("FAIL reset_mem_wr: got %b, required 0", mem_wr); end
    n_checks++; if (mem_data !== 16'h0)  begin n_fail++; $display("FAIL reset_mem_data: got %h, required 0000", mem_data); end
    n_checks++; if (mem_addr !== '0)     begin n_fail++; $display("FAIL reset_mem_addr: got %h, required 0", mem_addr); end
    n_checks++; if (cpu_run !== 1'b0)    begin n_fail++; $display("FAIL reset_cpu_run: got %b, required 0", cpu_run); end
    n_checks++; if (cpu_reset !== 1'b1)  begin n_fail++; $display("FAIL reset_cpu_reset: got %b, required 1", cpu_reset); end
    n_checks++; if (load_err !== 1'b0)   begin n_fail++; $display("FAIL reset_load_err: got %b, required 0", load_err); end
    n_checks++; if (dbg_state !== S_HDR_HI) begin n_fail++; $display("FAIL reset_state: got %0d, required %0d", dbg_state, S_HDR_HI); end
  endtask

  task automatic test_basic_load();
    send_byte(8'h00); idle(1);
    send_byte(8'h02); idle(1);
    send_byte(8'h10); idle(1);
    exp_q.push_back({AL'(0), 16'h1001});
    send_byte(8'h01); idle(1);
    send_byte(8'h20); idle(1);
    exp_q.push_back({AL'(1), 16'h2002});
    send_byte(8'h02);
`ifdef LOADER_CHECKSUM_EN
    idle(1);
    send_byte(8'h33);
    @(negedge clk);
`else
    @(negedge clk);
    n_checks++; if (mem_wr !== 1'b1)  begin n_fail++; $display("FAIL basic_last_wr: got %b, required 1", mem_wr); end
    n_checks++; if (cpu_run !== 1'b0) begin n_fail++; $display("FAIL basic_run_early: got %b, required 0", cpu_run); end
    n_checks++; if (dbg_state !== S_FINISH) begin n_fail++; $display("FAIL basic_finish: got %0d, required %0d", dbg_state, S_FINISH); end
    @(negedge clk);
`endif
    n_checks++; if (cpu_run !== 1'b1)   begin n_fail++; $display("FAIL basic_cpu_run: got %b, required 1", cpu_run); end
    n_checks++; if (cpu_reset !== 1'b0) begin n_fail++; $display("FAIL basic_cpu_reset: got %b, required 0", cpu_reset); end
    n_checks++; if (dbg_state !== S_RUN) begin n_fail++; $display("FAIL basic_state: got %0d, required %0d", dbg_state, S_RUN); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL basic_drain: %0d outstanding, required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_back_to_back();
    halt_cpu();
    load_stream(6, 0);
    wait_run("b2b");
  endtask

  task automatic test_run_mode();
    logic [AL-1:0] a;
    cpu_addr = AL'(5);
    rx_data  = 8'hAA;
    rx_valid = 1'b1;
    @(negedge clk);
    n_checks++; if (mem_addr !== AL'(5)) begin n_fail++; $display("FAIL run_addr5: got %h, required 5", mem_addr); end
    n_checks++; if (mem_wr !== 1'b0)     begin n_fail++; $display("FAIL run_wr: got %b, required 0", mem_wr); end
    @(posedge clk); #1;
    rx_valid = 1'b0;
    n_checks++; if (dbg_state !== S_RUN) begin n_fail++; $display("FAIL run_ignore_rx: got %0d, required %0d", dbg_state, S_RUN); end
    a = AL'($urandom_range(DEPTH - 1, 0));
    cpu_addr = a;
    #1;
    n_checks++; if (mem_addr !== a) begin n_fail++; $display("FAIL run_addr_comb: got %h, required %h", mem_addr, a); end
    halt_cpu();
    @(negedge clk);
    n_checks++; if (cpu_run !== 1'b0)    begin n_fail++; $display("FAIL halt_cpu_run: got %b, required 0", cpu_run); end
    n_checks++; if (cpu_reset !== 1'b1)  begin n_fail++; $display("FAIL halt_cpu_reset: got %b, required 1", cpu_reset); end
    n_checks++; if (dbg_state !== S_HALTED) begin n_fail++; $display("FAIL halt_state: got %0d, required %0d", dbg_state, S_HALTED); end
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h00);
    exp_q.push_back({AL'(0), 16'h0000});
    send_byte(8'h00);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h00);
`endif
    wait_run("reload");
  endtask

  task automatic test_zero_header();
    do_reset();
    send_byte(8'h00);
    send_byte(8'h00);
    @(negedge clk);
    n_checks++; if (load_err !== 1'b1) begin n_fail++; $display("FAIL zero_load_err: got %b, required 1", load_err); end
    n_checks++; if (dbg_state !== S_HDR_HI) begin n_fail++; $display("FAIL zero_state: got %0d, required %0d", dbg_state, S_HDR_HI); end
    idle(3);
    load_stream(1, 2);
    wait_run("after_zero");
    n_checks++; if (load_err !== 1'b1) begin n_fail++; $display("FAIL zero_sticky: got %b, required 1", load_err); end
  endtask

  task automatic test_reset_mid_load();
    halt_cpu();
    send_byte(8'h00);
    send_byte(8'h03);
    send_byte(8'h12);
    exp_q.push_back({AL'(0), 16'h1234});
    send_byte(8'h34);
    send_byte(8'h56);
    idle(2);
    // Reset must win over a simultaneous byte strobe and halt request.
    reset    = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'h78;
    cpu_halt = 1'b1;
    @(posedge clk); #1;
    reset    = 1'b0;
    rx_valid = 1'b0;
    cpu_halt = 1'b0;
    @(negedge clk);
    n_checks++; if (mem_wr !== 1'b0)     begin n_fail++; $display("FAIL mid_mem_wr: got %b, required 0", mem_wr); end
    n_checks++; if (mem_data !== 16'h0)  begin n_fail++; $display("FAIL mid_mem_data: got %h, required 0000", mem_data); end
    n_checks++; if (mem_addr !== '0)     begin n_fail++; $display("FAIL mid_mem_addr: got %h, required 0", mem_addr); end
    n_checks++; if (cpu_run !== 1'b0)    begin n_fail++; $display("FAIL mid_cpu_run: got %b, required 0", cpu_run); end
    n_checks++; if (cpu_reset !== 1'b1)  begin n_fail++; $display("FAIL mid_cpu_reset: got %b, required 1", cpu_reset); end
    n_checks++; if (load_err !== 1'b0)   begin n_fail++; $display("FAIL mid_load_err: got %b, required 0", load_err); end
    n_checks++; if (dbg_state !== S_HDR_HI) begin n_fail++; $display("FAIL mid_state: got %0d, required %0d", dbg_state, S_HDR_HI); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL mid_drain: %0d outstanding, required 0", exp_q.size()); exp_q.delete(); end
    load_stream(2, 1);
    wait_run("fresh");
  endtask

  task automatic test_overflow();
    halt_cpu();
    load_stream(DEPTH + 2, 0);
    wait_run("overflow");
    n_checks++; if (load_err !== 1'b1) begin n_fail++; $display("FAIL overflow_err: got %b, required 1", load_err); end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    halt_cpu();
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h12);
    exp_q.push_back({AL'(0), 16'h1234});
    send_byte(8'h34);
    send_byte(8'h26);
    @(negedge clk);
    n_checks++; if (dbg_state !== S_RUN) begin n_fail++; $display("FAIL csum_ok_state: got %0d, required %0d", dbg_state, S_RUN); end
    n_checks++; if (load_err !== 1'b0)   begin n_fail++; $display("FAIL csum_ok_err: got %b, required 0", load_err); end
    halt_cpu();
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h12);
    exp_q.push_back({AL'(0), 16'h1234});
    send_byte(8'h34);
    send_byte(8'h27);
    @(negedge clk);
    n_checks++; if (load_err !== 1'b1)   begin n_fail++; $display("FAIL csum_bad_err: got %b, required 1", load_err); end
    n_checks++; if (dbg_state !== S_HALTED) begin n_fail++; $display("FAIL csum_bad_state: got %0d, required %0d", dbg_state, S_HALTED); end
    n_checks++; if (cpu_run !== 1'b0)    begin n_fail++; $display("FAIL csum_bad_run: got %b, required 0", cpu_run); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL csum_drain: %0d outstanding, required 0", exp_q.size()); exp_q.delete(); end
  endtask
`endif

  // ---------------- sequence + report ----------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    cpu_addr = '0;
    cpu_halt = 1'b0;

    test_reset();
    test_basic_load();
    test_back_to_back();
    test_run_mode();
    test_zero_header();
    test_reset_mid_load();
    test_overflow();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
